// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the register file and its read ports.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_32x32_reg_read_port.sv
// One combinational read port of the register file.
// The port decodes the address, forces register 0 to read as zero, and
// optionally forwards the in-flight write data when it targets the same address.
module reg_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  rd_addr,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  rd_data
);

  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic zero_hit_s;
  logic bypass_hit_s;

  // A write to register 0 is never forwarded, because register 0 is hard-wired.
  always_comb begin
    zero_hit_s   = (rd_addr == ZERO_ADDR);
    bypass_hit_s = 1'b0;
    if (BYPASS && wr_en && (wr_addr == rd_addr) && (wr_addr != ZERO_ADDR)) begin
      bypass_hit_s = 1'b1;
    end else begin
      bypass_hit_s = 1'b0;
    end
  end

  // Select the read data. Register 0 takes priority, then forwarding, then storage.
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    if (zero_hit_s) begin
      rd_data = {DATA_W{1'b0}};
    end else if (bypass_hit_s) begin
      rd_data = wr_data;
    end else begin
      rd_data = regs[rd_addr];
    end
  end

endmodule

// File: rtl/register_file_32x32.sv
// MIPS general-purpose register file with two combinational read ports and one clocked write port.
// Register 0 has no storage. Each read port returns it as constant zero.
module register_file_32x32 #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  import mips_pkg::*;

  localparam int REGS_N = 2**ADDR_W;

  logic [DATA_W-1:0]             regs_r [REGS_N-1:1];
  logic [REGS_N-1:0][DATA_W-1:0] regs_s;
  logic                          wr_en_s;

  // While reset is asserted no write is pending, so nothing may be forwarded.
  // This keeps both read ports at zero during reset.
  assign wr_en_s = wr_en & rst_n;

  // Storage for registers 1..N-1.
  // Reset is asynchronous. The write enable is checked first, so an unknown
  // wr_addr with wr_en low leaves the state unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REGS_N; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en) begin
      for (int i = 1; i < REGS_N; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          regs_r[i] <= wr_data;
        end
      end
    end
  end

  // Present the storage to the read ports as one packed view.
  // Slot 0 is tied to zero.
  always_comb begin
    regs_s[0] = {DATA_W{1'b0}};
    for (int i = 1; i < REGS_N; i++) begin
      regs_s[i] = regs_r[i];
    end
  end

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_a (
    .regs    (regs_s),
    .rd_addr (rd_addr_a),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data_a)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_b (
    .regs    (regs_s),
    .rd_addr (rd_addr_b),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data_b)
  );

endmodule

// File: tb/tb_register_file_32x32.sv
// Directed bench for register_file_32x32.
// Two instances share the same stimulus: one with forwarding enabled and one without.
// A behavioural array model is compared on every falling edge. Literal checks pin the model.
`timescale 1ns/1ps
module tb_register_file_32x32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rda1, rdb1, rda0, rdb0;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  logic [31:0] m [32];

  register_file_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda1), .rd_data_b(rdb1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  register_file_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda0), .rd_data_b(rdb0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural state: a reset clears everything, and a write lands on the edge unless it targets reg 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m[i] <= 32'd0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      m[wr_addr] <= wr_data;
    end
  end

  function automatic logic [31:0] mread(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && rst_n && wr_en && (wr_addr == a)) return wr_data;
    return m[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #1;
    wr_en     = wen;
    wr_addr   = waddr;
    wr_data   = wdata;
    rd_addr_a = ra;
    rd_addr_b = rb;
  endtask

  function automatic logic [31:0] inv_exp(input int a);
    return (a == 0) ? 32'd0 : ~32'(a);
  endfunction

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_a_byp1", rda1, mread(rd_addr_a, 1'b1));
      chk("model_b_byp1", rdb1, mread(rd_addr_b, 1'b1));
      chk("model_a_byp0", rda0, mread(rd_addr_a, 1'b0));
      chk("model_b_byp0", rdb0, mread(rd_addr_b, 1'b0));
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    rst_n     = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 5'd5;
    wr_data   = 32'hDEADBEEF;
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    chk_on    = 1'b1;

    // 1. Reset held with a write pending. Nothing is written, and every address reads 0.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_en = 1'b0;
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
      #1;
      chk("reset_a", rda1, 32'd0);
      chk("reset_b", rdb1, 32'd0);
      chk("reset_a0", rda0, 32'd0);
    end

    // 2. Basic write, then read the written register and an untouched neighbour.
    drive(1'b1, 5'd8, 32'h12345678, 5'd8, 5'd9);
    drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd9);
    #1;
    chk("wr_rd_8", rda1, 32'h12345678);
    chk("rd_9", rdb1, 32'd0);

    // 3. A write to register 0 is neither forwarded nor stored.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    chk("zero_same_byp1", rda1, 32'd0);
    chk("zero_same_byp0", rda0, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1;
    chk("zero_later", rda1, 32'd0);

    // 4. Forwarding on both ports at once, compared with the non-forwarding instance.
    drive(1'b1, 5'd3, 32'hAAAA0000, 5'd1, 5'd2);
    drive(1'b1, 5'd3, 32'h0000BBBB, 5'd3, 5'd3);
    #1;
    chk("byp1_a", rda1, 32'h0000BBBB);
    chk("byp1_b", rdb1, 32'h0000BBBB);
    chk("byp0_a", rda0, 32'hAAAA0000);
    chk("byp0_b", rdb0, 32'hAAAA0000);
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    #1;
    chk("byp0_after_a", rda0, 32'h0000BBBB);
    chk("byp0_after_b", rdb0, 32'h0000BBBB);

    // An unknown write address with wr_en low must leave the state unchanged.
    drive(1'b0, 5'bxxxxx, 32'h55555555, 5'd3, 5'd8);
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd8);
    #1;
    chk("xaddr_3", rda1, 32'h0000BBBB);
    chk("xaddr_8", rdb0, 32'h12345678);

    // 5. Fill the file, then assert reset between clock edges.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 5'd0, 5'd0);
    end
    drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd17);
    #1;
    chk("fill_31", rda1, 32'h0000011F);
    chk("fill_17", rdb0, 32'h00000111);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_a1", rda1, 32'd0);
    chk("async_b1", rdb1, 32'd0);
    chk("async_a0", rda0, 32'd0);
    chk("async_b0", rdb0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 6. Write ~index everywhere, then sweep the address pairs (a, 31-a).
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), ~32'(i), 5'd0, 5'd0);
    end
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
      #1;
      chk("sweep_a1", rda1, inv_exp(a));
      chk("sweep_b1", rdb1, inv_exp(31 - a));
      chk("sweep_a0", rda0, inv_exp(a));
      chk("sweep_b0", rdb0, inv_exp(31 - a));
    end

    @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
